// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: memory geometry, FSM encoding and
// the set of states in which the loader takes host bytes.
package prog_loader_pkg;

   localparam int PROG_ADDR_W = 12;
   localparam int PROG_DATA_W = 8;

   typedef enum logic [2:0] {
      LD_IDLE   = 3'd0,
      LD_LEN_HI = 3'd1,
      LD_LEN_LO = 3'd2,
      LD_DATA   = 3'd3,
      LD_CHK    = 3'd4,
      LD_DONE   = 3'd5,
      LD_ERR    = 3'd6
   } ld_state_e;

   // States that accept a host byte; also exactly the states where a frame is in progress.
   function automatic logic takes_bytes(input ld_state_e s);
      return s inside {LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CHK};
   endfunction

endpackage

// File: rtl/load_addr_cnt.sv
// Up-counter with synchronous load (priority) and count enable, asynchronous
// active-high reset; used for both the write address and the byte countdown.
module load_addr_cnt #(
   parameter int           W       = 12,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     cnt <= RST_VAL;
      else if (load) cnt <= load_val;
      else if (en)   cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream writer for the 4096x8 program memory: length, data, checksum.
// Holds the CPU in reset while loading and releases it only after a good checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                ADDR_W    = PROG_ADDR_W,
   parameter int                DATA_W    = PROG_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int HI_W = ADDR_W - 8;

   ld_state_e         state, next_state;
   logic [HI_W-1:0]   len_hi;
   logic [DATA_W-1:0] sum, chk_expect;
   logic [ADDR_W-1:0] addr_cnt, rem_cnt, len_full, rem_load_val;
   logic              xfer, start_go, len_lo_xfer, data_xfer, last_byte;

   // The countdown is loaded with -len and counts up, so the last data byte is
   // the one accepted while it reads all-ones; len==0 naturally yields 4096 bytes.
   assign len_full     = {len_hi, in_data[7:0]};
   assign rem_load_val = '0 - len_full;
   assign chk_expect   = '0 - sum;

   assign xfer        = in_valid && in_ready;
   assign start_go    = start && (state inside {LD_IDLE, LD_DONE, LD_ERR});
   assign len_lo_xfer = xfer && (state == LD_LEN_LO);
   assign data_xfer   = xfer && (state == LD_DATA);
   assign last_byte   = (rem_cnt == '1);

   load_addr_cnt #(.W(ADDR_W), .RST_VAL(BASE_ADDR)) u_addr_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (start_go),
      .en       (data_xfer),
      .load_val (BASE_ADDR),
      .cnt      (addr_cnt)
   );

   load_addr_cnt #(.W(ADDR_W), .RST_VAL('0)) u_rem_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (len_lo_xfer),
      .en       (data_xfer),
      .load_val (rem_load_val),
      .cnt      (rem_cnt)
   );

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         LD_IDLE, LD_DONE, LD_ERR: if (start)                  next_state = LD_LEN_HI;
         LD_LEN_HI:                if (xfer)                   next_state = LD_LEN_LO;
         LD_LEN_LO:                if (xfer)                   next_state = LD_DATA;
         LD_DATA:                  if (xfer && last_byte)      next_state = LD_CHK;
         LD_CHK:                   if (xfer)                   next_state = (in_data == chk_expect) ? LD_DONE : LD_ERR;
         default:                                              next_state = LD_IDLE;
      endcase
   end

   // Status outputs are registered from next_state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= LD_IDLE;
         len_hi    <= '0;
         sum       <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         cpu_hold  <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
      end else begin
         state    <= next_state;
         in_ready <= takes_bytes(next_state);
         busy     <= takes_bytes(next_state);
         done     <= (next_state == LD_DONE);
         error    <= (next_state == LD_ERR);
         cpu_hold <= (next_state != LD_DONE);
         mem_we   <= data_xfer;
         if (xfer && state == LD_LEN_HI) len_hi <= in_data[HI_W-1:0];
         if (start_go)
            sum <= '0;
         else if (data_xfer)
            sum <= sum + in_data;
         if (data_xfer) begin
            mem_addr  <= addr_cnt;
            mem_wdata <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (base 000 and FFF) share clock and reset;
// stimulus pushes expected writes, per-instance monitors pop and compare on every mem_we.
module tb_prog_loader;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_s [2];
   logic       valid_s [2];
   logic [7:0] data_s  [2];

   logic        in_ready_0, mem_we_0, cpu_hold_0, busy_0, done_0, error_0;
   logic        in_ready_1, mem_we_1, cpu_hold_1, busy_1, done_1, error_1;
   logic [11:0] mem_addr_0, mem_addr_1;
   logic [7:0]  mem_wdata_0, mem_wdata_1;

   logic        rdy [2], we [2], hold [2], bsy [2], dn [2], er [2];
   logic [11:0] maddr [2];
   logic [7:0]  mwd [2];

   assign rdy[0] = in_ready_0;   assign rdy[1] = in_ready_1;
   assign we[0]  = mem_we_0;     assign we[1]  = mem_we_1;
   assign hold[0] = cpu_hold_0;  assign hold[1] = cpu_hold_1;
   assign bsy[0] = busy_0;       assign bsy[1] = busy_1;
   assign dn[0]  = done_0;       assign dn[1]  = done_1;
   assign er[0]  = error_0;      assign er[1]  = error_1;
   assign maddr[0] = mem_addr_0; assign maddr[1] = mem_addr_1;
   assign mwd[0] = mem_wdata_0;  assign mwd[1] = mem_wdata_1;

   wr_t q0 [$];
   wr_t q1 [$];
   int  tests = 0;
   int  fails = 0;

   prog_loader #(.BASE_ADDR(12'h000)) dut0 (
      .clk (clk), .reset (reset), .start (start_s[0]), .in_valid (valid_s[0]), .in_data (data_s[0]),
      .in_ready (in_ready_0), .mem_we (mem_we_0), .mem_addr (mem_addr_0), .mem_wdata (mem_wdata_0),
      .cpu_hold (cpu_hold_0), .busy (busy_0), .done (done_0), .error (error_0)
   );

   prog_loader #(.BASE_ADDR(12'hFFF)) dut1 (
      .clk (clk), .reset (reset), .start (start_s[1]), .in_valid (valid_s[1]), .in_data (data_s[1]),
      .in_ready (in_ready_1), .mem_we (mem_we_1), .mem_addr (mem_addr_1), .mem_wdata (mem_wdata_1),
      .cpu_hold (cpu_hold_1), .busy (busy_1), .done (done_1), .error (error_1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s", name);
   endtask

   // Monitors: every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      wr_t e;
      if (mem_we_0 === 1'b1) begin
         if (q0.size() == 0) fail_now("dut0 unexpected write");
         else begin
            e = q0.pop_front();
            check("dut0 wr addr", mem_addr_0, e.addr);
            check("dut0 wr data", mem_wdata_0, e.data);
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (mem_we_1 === 1'b1) begin
         if (q1.size() == 0) fail_now("dut1 unexpected write");
         else begin
            e = q1.pop_front();
            check("dut1 wr addr", mem_addr_1, e.addr);
            check("dut1 wr data", mem_wdata_1, e.data);
         end
      end
   end

   task automatic check_reset_vals(input int d, input logic [11:0] base);
      check("rst in_ready", rdy[d], 0);
      check("rst mem_we", we[d], 0);
      check("rst mem_addr", maddr[d], base);
      check("rst mem_wdata", mwd[d], 0);
      check("rst cpu_hold", hold[d], 1);
      check("rst busy", bsy[d], 0);
      check("rst done", dn[d], 0);
      check("rst error", er[d], 0);
   endtask

   task automatic do_start(input int d);
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
   endtask

   // Holds the byte until the DUT takes it; in_ready only changes on posedge,
   // so the value seen at the negedge is what the next posedge uses.
   task automatic send_byte(input int d, input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      valid_s[d] = 1'b1;
      data_s[d]  = b;
      for (int i = 0; i < 50; i++) begin
         ok = rdy[d];
         @(negedge clk);
         if (ok) break;
      end
      valid_s[d] = 1'b0;
      if (!ok) fail_now("send_byte timeout");
   endtask

   task automatic send_data(input int d, input logic [11:0] addr, input logic [7:0] b);
      wr_t e;
      e.addr = addr;
      e.data = b;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      send_byte(d, b);
   endtask

   task automatic wait_status(input int d, input logic exp_done, input logic exp_err, input string name);
      for (int i = 0; i < 20 && !(dn[d] || er[d]); i++) @(negedge clk);
      check({name, " done"}, dn[d], exp_done);
      check({name, " error"}, er[d], exp_err);
      check({name, " cpu_hold"}, hold[d], !exp_done);
      check({name, " busy"}, bsy[d], 0);
      check({name, " queue drained"}, (d == 0) ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         valid_s[d] = 1'b0;
         data_s[d]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      check_reset_vals(0, 12'h000);
      check_reset_vals(1, 12'hFFF);
      reset = 1'b0;
      @(negedge clk);

      // Bytes offered while idle are neither accepted nor written.
      valid_s[0] = 1'b1;
      data_s[0]  = 8'h77;
      repeat (3) begin
         @(negedge clk);
         check("idle in_ready", rdy[0], 0);
      end
      valid_s[0] = 1'b0;

      // Basic frame: A1+B2+C3 = 0x216 -> chk 0xEA.
      do_start(0);
      check("start busy", bsy[0], 1);
      send_byte(0, 8'h00);
      send_byte(0, 8'h03);
      send_data(0, 12'h000, 8'hA1);
      send_data(0, 12'h001, 8'hB2);
      send_data(0, 12'h002, 8'hC3);
      send_byte(0, 8'hEA);
      wait_status(0, 1'b1, 1'b0, "good frame");

      // Reload from DONE with a wrong checksum: same data rewritten, error raised.
      do_start(0);
      check("reload cpu_hold", hold[0], 1);
      check("reload done cleared", dn[0], 0);
      check("reload busy", bsy[0], 1);
      send_byte(0, 8'h00);
      send_byte(0, 8'h03);
      send_data(0, 12'h000, 8'hA1);
      send_data(0, 12'h001, 8'hB2);
      send_data(0, 12'h002, 8'hC3);
      send_byte(0, 8'hEB);
      wait_status(0, 1'b0, 1'b1, "bad chk");

      // Address wrap on the FFF-based instance: 11+22 = 0x33 -> chk 0xCD.
      do_start(1);
      send_byte(1, 8'h00);
      send_byte(1, 8'h02);
      send_data(1, 12'hFFF, 8'h11);
      send_data(1, 12'h000, 8'h22);
      send_byte(1, 8'hCD);
      wait_status(1, 1'b1, 1'b0, "wrap");

      // Gapped valid from ERR, with start pulsed mid-frame: 5A+3C+0F = 0xA5 -> chk 0x5B.
      do_start(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h03);
      send_data(0, 12'h000, 8'h5A);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      check("start ignored busy", bsy[0], 1);
      send_data(0, 12'h001, 8'h3C);
      @(negedge clk);
      send_data(0, 12'h002, 8'h0F);
      @(negedge clk);
      send_byte(0, 8'h5B);
      wait_status(0, 1'b1, 1'b0, "gapped");

      // Async reset after the second of five data bytes, then a clean load: 1+2+3 -> chk 0xFA.
      do_start(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h05);
      send_data(0, 12'h000, 8'h10);
      send_data(0, 12'h001, 8'h20);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_vals(0, 12'h000);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_start(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h03);
      send_data(0, 12'h000, 8'h01);
      send_data(0, 12'h001, 8'h02);
      send_data(0, 12'h002, 8'h03);
      send_byte(0, 8'hFA);
      wait_status(0, 1'b1, 1'b0, "after reset");

      // Full image: len 0 means 4096 bytes of 01; sum wraps to 0 -> chk 0x00.
      do_start(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h00);
      for (int i = 0; i < 4096; i++) begin
         logic [11:0] a;
         a = 12'(i);
         send_data(0, a, 8'h01);
      end
      send_byte(0, 8'h00);
      wait_status(0, 1'b1, 1'b0, "full image");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
